// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port dmem syncram between port 0 (processor load/store) and
// port 1 (loader/debug DMA). One transaction is in flight at a time. Port 0 has
// fixed priority, but after MAX_STREAK consecutive contested port-0 grants the
// next contested grant goes to port 1 (MAX_STREAK = 0 gives strict priority).
//
// Ports
//   clock, reset            dmem-domain clock, synchronous active-high reset
//   p<n>_valid/we/addr/wdata request from port n (held stable until ready)
//   p<n>_ready              request accepted at the coming rising edge
//   p<n>_rvalid             one-cycle read-data-valid pulse for port n
//   rdata                   shared read data, held until the next read capture
//   address_dmem/data/wren  to the dmem instance
//   q_dmem                  from the dmem instance
//   busy                    transaction in progress (state != IDLE)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int READ_LAT   = 1,
   parameter int MAX_STREAK = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              p0_valid,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ready,
   output logic              p0_rvalid,
   input  logic              p1_valid,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ready,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] address_dmem,
   output logic [DATA_W-1:0] data,
   output logic              wren,
   input  logic [DATA_W-1:0] q_dmem,
   output logic              busy
);

   localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;
   localparam int STK_W = $clog2(MAX_STREAK + 2);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);
   localparam logic [STK_W-1:0] STK_ONE  = STK_W'(1);
   localparam logic             GUARD_EN = (MAX_STREAK != 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RD    = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [STK_W-1:0]    streak_q, streak_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                we_q;
   logic                owner_q;
   logic                wren_q;
   logic                p0_rvalid_q;
   logic                p1_rvalid_q;

   logic                p0_win_s;
   logic                p1_win_s;
   logic                acc_s;
   logic                rd_done_s;

   // Arbitration, ready generation and next-state logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      streak_d = streak_q;

      // Port 1 wins when alone, or when the starvation guard has tripped.
      p1_win_s = p1_valid & (~p0_valid | (GUARD_EN & (streak_q == STK_MAX)));
      p0_win_s = p0_valid & ~p1_win_s;

      p0_ready = (state_q == S_IDLE) & ~reset & p0_win_s;
      p1_ready = (state_q == S_IDLE) & ~reset & p1_win_s;
      acc_s    = p0_ready | p1_ready;

      rd_done_s = (state_q == S_RD) && (cnt_q == CNT_ONE);

      case (state_q)
         S_IDLE: begin
            if (acc_s) begin
               state_d = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
            // Streak only counts port-0 wins that actually held port 1 off.
            if (p1_ready || !p1_valid) begin
               streak_d = '0;
            end else if (p0_ready && (streak_q != STK_MAX)) begin
               streak_d = streak_q + STK_ONE;
            end else begin
               streak_d = streak_q;
            end
         end
         S_ISSUE: begin
            if (we_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RD;
               cnt_d   = CNT_INIT;
            end
         end
         S_RD: begin
            if (cnt_q == CNT_ONE) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, request latch, dmem drive and response registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         streak_q    <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         we_q        <= 1'b0;
         owner_q     <= 1'b0;
         wren_q      <= 1'b0;
         p0_rvalid_q <= 1'b0;
         p1_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         streak_q    <= streak_d;
         p0_rvalid_q <= rd_done_s & ~owner_q;
         p1_rvalid_q <= rd_done_s & owner_q;
         if (rd_done_s) begin
            rdata_q <= q_dmem;
         end
         // wren is registered on accept so it is high exactly for the ISSUE cycle.
         if (acc_s) begin
            addr_q  <= p1_ready ? p1_addr  : p0_addr;
            wdata_q <= p1_ready ? p1_wdata : p0_wdata;
            we_q    <= p1_ready ? p1_we    : p0_we;
            wren_q  <= p1_ready ? p1_we    : p0_we;
            owner_q <= p1_ready;
         end else begin
            wren_q  <= 1'b0;
         end
      end
   end

   assign address_dmem = addr_q;
   assign data         = wdata_q;
   assign wren         = wren_q;
   assign rdata        = rdata_q;
   assign p0_rvalid    = p0_rvalid_q;
   assign p1_rvalid    = p1_rvalid_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter with a behavioural READ_LAT=1 syncram.
// Read expectations are queued at accept time and matched on rvalid.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int RL = 1;

   logic        clock = 1'b0;
   logic        reset;
   logic        p0_valid, p0_we, p0_ready, p0_rvalid;
   logic [11:0] p0_addr;
   logic [31:0] p0_wdata;
   logic        p1_valid, p1_we, p1_ready, p1_rvalid;
   logic [11:0] p1_addr;
   logic [31:0] p1_wdata;
   logic [31:0] rdata;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int          port;
      logic [31:0] d;
      int          acc_e;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [int];
   int          glog[$];
   logic        log_en = 1'b0;
   logic        prev_rv = 1'b0;
   logic        overlap_seen = 1'b0;
   logic [31:0] mem [0:4095];

   always #5 clock = ~clock;

   dmem_arbiter dut (
      .clock(clock), .reset(reset),
      .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ready(p0_ready), .p0_rvalid(p0_rvalid),
      .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ready(p1_ready), .p1_rvalid(p1_rvalid),
      .rdata(rdata), .address_dmem(address_dmem), .data(data), .wren(wren),
      .q_dmem(q_dmem), .busy(busy)
   );

   // Single-port syncram, registered address, one-cycle read latency.
   always @(posedge clock) begin
      if (wren) mem[address_dmem] <= data;
      q_dmem <= mem[address_dmem];
   end

   always @(posedge clock) cyc = cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor / scoreboard: sampled on the falling edge.
   always @(negedge clock) begin
      if (reset) begin
         sb.delete();
         prev_rv = 1'b0;
      end else begin
         if (p0_rvalid || p1_rvalid) begin
            exp_t e;
            chk("rvalid_onehot", p0_rvalid & p1_rvalid, 0);
            chk("rvalid_pulse", prev_rv, 0);
            chk("rvalid_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("rv_port", p1_rvalid, e.port);
               chk("rdata", rdata, e.d);
               chk("rd_latency", cyc - e.acc_e, RL + 1);
            end
            if (p0_rvalid && p1_valid && p1_ready) overlap_seen = 1'b1;
         end
         prev_rv = p0_rvalid | p1_rvalid;
         if (p0_valid && p1_valid) chk("ready_onehot", p0_ready & p1_ready, 0);
         if (p0_valid && p0_ready) begin
            if (p0_we) ref_mem[int'(p0_addr)] = p0_wdata;
            else sb.push_back('{0, ref_mem[int'(p0_addr)], cyc + 1});
            if (log_en) glog.push_back(0);
         end
         if (p1_valid && p1_ready) begin
            if (p1_we) ref_mem[int'(p1_addr)] = p1_wdata;
            else sb.push_back('{1, ref_mem[int'(p1_addr)], cyc + 1});
            if (log_en) glog.push_back(1);
         end
      end
   end

   // Present one request on a port and hold it until accepted (bounded).
   task automatic drive(input int port, input logic we, input logic [11:0] a,
                        input logic [31:0] d);
      int   waited;
      logic rdy;
      if (port == 0) begin
         p0_valid = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
      end else begin
         p1_valid = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
      end
      waited = 0;
      do begin
         @(negedge clock);
         rdy = (port == 0) ? p0_ready : p1_ready;
         waited++;
      end while (!rdy && waited < 100);
      chk("accepted", rdy, 1);
      @(posedge clock); #1;
      if (port == 0) p0_valid = 1'b0;
      else p1_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pat[10];
      pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

      reset = 1'b1;
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 12'h000; p0_wdata = 32'h0;
      p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 12'h000; p1_wdata = 32'h0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_p0_ready", p0_ready, 0);
      chk("rst_p1_ready", p1_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wren", wren, 0);
      chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_addr", address_dmem, 0);
      @(posedge clock); #1;
      reset = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
      idle_cycles(1);

      // 1: write, wren exactly one cycle
      drive(0, 1'b1, 12'h010, 32'hDEADBEEF);
      @(negedge clock);
      chk("t1_wren", wren, 1);
      chk("t1_addr", address_dmem, 12'h010);
      chk("t1_data", data, 32'hDEADBEEF);
      chk("t1_busy", busy, 1);
      @(negedge clock);
      chk("t1_wren_off", wren, 0);
      chk("t1_busy_off", busy, 0);
      idle_cycles(1);

      // 2: read back through the scoreboard
      drive(0, 1'b0, 12'h010, 32'h0);
      idle_cycles(4);
      chk("t2_rdata_hold", rdata, 32'hDEADBEEF);

      // 3: simultaneous requests, port 0 first then port 1
      fork
         drive(0, 1'b1, 12'h020, 32'h12345678);
         drive(1, 1'b0, 12'h020, 32'h0);
         begin
            @(negedge clock);
            chk("t3_p0_ready", p0_ready, 1);
            chk("t3_p1_ready", p1_ready, 0);
         end
      join
      idle_cycles(5);

      // 4: continuous contention, starvation guard
      log_en = 1'b1;
      fork
         repeat (8) drive(0, 1'b1, 12'h100, 32'hA0A0A0A0);
         repeat (2) drive(1, 1'b1, 12'h200, 32'hB0B0B0B0);
      join
      log_en = 1'b0;
      chk("t4_grants", glog.size(), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < glog.size()) chk("t4_grant_port", glog[i], pat[i]);
      end
      idle_cycles(3);

      // 6: port-1 read accepted in the port-0 rvalid cycle
      fork
         drive(0, 1'b0, 12'h010, 32'h0);
         begin
            @(posedge clock); #1;
            drive(1, 1'b0, 12'h020, 32'h0);
         end
      join
      idle_cycles(5);
      chk("t6_overlap", overlap_seen, 1);

      // 5: reset while in RD
      drive(0, 1'b0, 12'h100, 32'h0);
      @(posedge clock); #1;
      chk("t5_busy_rd", busy, 1);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("t5_busy", busy, 0);
      chk("t5_wren", wren, 0);
      chk("t5_rvalid", p0_rvalid, 0);
      chk("t5_rdata", rdata, 0);
      reset = 1'b0;
      idle_cycles(6);

      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
